// File: rtl/dvlsi_pkg.sv
// rtl/dvlsi_pkg.sv - shared tile-MMA command and tensor-core interface types
package dvlsi_pkg;

    localparam int TMMA_Q_DEPTH = 4;

    typedef struct packed {
        logic [13:0] ctrl;
        logic [7:0]  tm;
        logic [7:0]  tk;
        logic [7:0]  tn;
        logic [31:0] lhs_addr;
        logic [31:0] rhs_addr;
        logic [31:0] acc_addr;
        logic [31:0] dst_addr;
    } tmma_req_t;

    typedef struct packed {
        logic      tensor_core_valid;
        tmma_req_t tmma_req;
    } tensor_core_req_t;

    typedef struct packed {
        logic tensor_core_ready;
        logic tensor_core_done;
    } tensor_core_resp_t;

    typedef enum logic [1:0] {
        TMMA_Q_IDLE      = 2'd0,
        TMMA_Q_ISSUE     = 2'd1,
        TMMA_Q_WAIT_DONE = 2'd2
    } tmma_q_state_e;

    // A tile with any zero dimension describes no work and must not reach the core.
    function automatic logic tmma_req_valid(input tmma_req_t req);
        return (req.tm != '0) && (req.tk != '0) && (req.tn != '0);
    endfunction

endpackage

// File: rtl/tmma_cmd_fifo.sv
// rtl/tmma_cmd_fifo.sv - non-fall-through command FIFO with combinational head
module tmma_cmd_fifo
    import dvlsi_pkg::*;
#(
    parameter int DEPTH = TMMA_Q_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  tmma_req_t        wdata,
    input  logic             pop,
    output tmma_req_t        rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    tmma_req_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/tmma_cmd_queue.sv
// rtl/tmma_cmd_queue.sv - tile-MMA command queue with single-issue FSM and fence
module tmma_cmd_queue
    import dvlsi_pkg::*;
#(
    parameter int DEPTH = TMMA_Q_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 2)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  tmma_req_t         cmd_i,
    output tensor_core_req_t  tc_req_o,
    input  tensor_core_resp_t tc_resp_i,
    input  logic              fence_req_i,
    output logic              fence_ack_o,
    output logic [CNT_W-1:0]  outstanding_o,
    output logic              cmd_err_o,
    output logic              spurious_done_o
);

    localparam int FCNT_W = $clog2(DEPTH + 1);

    logic              full;
    logic              empty;
    logic [FCNT_W-1:0] fifo_count;
    logic [FCNT_W-1:0] count_next;
    tmma_req_t         head;

    tmma_q_state_e     state;
    tmma_q_state_e     state_next;

    logic              cmd_hs;
    logic              push;
    logic              pop;
    logic              fence_pend;
    logic              fence_done;
    logic              req_valid;
    tmma_req_t         req_q;
    logic [CNT_W-1:0]  outstanding_q;
    logic              fence_ack_q;
    logic              cmd_err_q;
    logic              spurious_q;

    assign cmd_ready_o = !full && !fence_pend;
    assign cmd_hs      = cmd_valid_i && cmd_ready_o;
    assign push        = cmd_hs && tmma_req_valid(cmd_i);
    // The entry stays in the FIFO while being presented; it leaves on the core's accept.
    assign pop         = (state == TMMA_Q_ISSUE) && tc_resp_i.tensor_core_ready;

    tmma_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .wdata  (cmd_i),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            TMMA_Q_IDLE:      if (!empty) state_next = TMMA_Q_ISSUE;
            TMMA_Q_ISSUE:     if (tc_resp_i.tensor_core_ready) state_next = TMMA_Q_WAIT_DONE;
            TMMA_Q_WAIT_DONE: if (tc_resp_i.tensor_core_done) state_next = TMMA_Q_IDLE;
            default:          state_next = TMMA_Q_IDLE;
        endcase
    end

    assign count_next = fifo_count + FCNT_W'(push) - FCNT_W'(pop);

    // Evaluated on next-cycle occupancy so the ack lands the cycle after the last done.
    assign fence_done = (fence_pend || fence_req_i) && (count_next == '0)
                        && (state_next == TMMA_Q_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= TMMA_Q_IDLE;
            req_valid     <= 1'b0;
            req_q         <= '0;
            outstanding_q <= '0;
            fence_pend    <= 1'b0;
            fence_ack_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == TMMA_Q_IDLE) && !empty) begin
                req_valid <= 1'b1;
                req_q     <= head;
            end else if (pop) begin
                req_valid <= 1'b0;
            end
            outstanding_q <= CNT_W'(count_next) + CNT_W'(state_next != TMMA_Q_IDLE);
            cmd_err_q     <= cmd_hs && !tmma_req_valid(cmd_i);
            spurious_q    <= tc_resp_i.tensor_core_done && (state != TMMA_Q_WAIT_DONE);
            fence_ack_q   <= fence_done;
            if (fence_done) begin
                fence_pend <= 1'b0;
            end else if (fence_req_i) begin
                fence_pend <= 1'b1;
            end
        end
    end

    assign tc_req_o        = '{tensor_core_valid: req_valid, tmma_req: req_q};
    assign outstanding_o   = outstanding_q;
    assign fence_ack_o     = fence_ack_q;
    assign cmd_err_o       = cmd_err_q;
    assign spurious_done_o = spurious_q;

endmodule
